ctrl_pipe_seq: RTL

//  Pipelined control unit for the 32-bit RISC core. Decodes the ID-stage opcode into a control bundle.

---
 rtl/ctrl_pkg.sv | 49 ++++
 rtl/ctrl_pipe_seq_if.sv | 46 ++++
 rtl/ctrl_decode.sv | 31 +++
 rtl/ctrl_pipe_seq.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined control unit: opcodes, ALU ops,
// write-back source selects, the control bundle carried down the pipe, and the MUL FSM states.
package ctrl_pkg;

    localparam logic [7:0] OP_ADD  = 8'h08;
    localparam logic [7:0] OP_MUL  = 8'h18;
    localparam logic [7:0] OP_ADDI = 8'h03;
    localparam logic [7:0] OP_SW   = 8'h19;
    localparam logic [7:0] OP_LW   = 8'h31;
    localparam logic [7:0] OP_JAL  = 8'h04;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_MUL = 4'b0010;

    localparam logic [1:0] SRC_REG = 2'b00;
    localparam logic [1:0] SRC_IMM = 2'b01;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] alu_src;
        logic [3:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic       pc_src;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

    // Source-register usage, consulted only by the load-use interlock.
    function automatic logic uses_rs1(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_ADDI) ||
               (op == OP_SW)  || (op == OP_LW);
    endfunction

    function automatic logic uses_rs2(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/ctrl_pipe_seq_if.sv
// Bus between the IF/ID register, the datapath stage registers and ctrl_pipe_seq.
// Handshake: an ID instruction is consumed at a rising edge where id_ready=1 (id_valid qualifies it).
interface ctrl_pipe_seq_if #(
    parameter int OP_W  = 8,
    parameter int REG_W = 5
);
    import ctrl_pkg::*;

    logic             id_valid;
    logic [OP_W-1:0]  id_op;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] id_rd;
    logic             ext_stall;

    logic             id_ready;
    logic             pc_src;
    logic             flush_if;
    logic             ex_valid;
    logic [1:0]       ex_alu_src;
    logic [3:0]       ex_alu_op;
    logic             ex_mul_done;
    logic             mem_valid;
    logic             mem_read;
    logic             mem_write;
    logic             wb_valid;
    logic [1:0]       wb_mem_to_reg;
    logic             wb_reg_write;
    logic [REG_W-1:0] wb_rd;
    mul_state_e       dbg_mul_state;

    modport master (
        output id_valid, id_op, id_rs1, id_rs2, id_rd, ext_stall,
        input  id_ready, pc_src, flush_if, ex_valid, ex_alu_src, ex_alu_op, ex_mul_done,
               mem_valid, mem_read, mem_write, wb_valid, wb_mem_to_reg, wb_reg_write, wb_rd,
               dbg_mul_state
    );

    modport slave (
        input  id_valid, id_op, id_rs1, id_rs2, id_rd, ext_stall,
        output id_ready, pc_src, flush_if, ex_valid, ex_alu_src, ex_alu_op, ex_mul_done,
               mem_valid, mem_read, mem_write, wb_valid, wb_mem_to_reg, wb_reg_write, wb_rd,
               dbg_mul_state
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: ID opcode -> control bundle.
// Unknown opcodes or an empty ID slot decode to an all-zero bubble with known_o=0.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 8
) (
    input  logic [OP_W-1:0] op_i,
    input  logic            valid_i,
    output ctrl_t           ctrl_o,
    output logic            known_o
);

    always_comb begin
        ctrl_o  = CTRL_NOP;
        known_o = 1'b0;
        if (valid_i) begin
            known_o = 1'b1;
            case (op_i)
                OP_ADD:  ctrl_o = '{1'b1, SRC_REG, ALU_ADD, 1'b0, 1'b0, M2R_ALU, 1'b0};
                OP_MUL:  ctrl_o = '{1'b1, SRC_REG, ALU_MUL, 1'b0, 1'b0, M2R_ALU, 1'b0};
                OP_ADDI: ctrl_o = '{1'b1, SRC_IMM, ALU_ADD, 1'b0, 1'b0, M2R_ALU, 1'b0};
                OP_SW:   ctrl_o = '{1'b0, SRC_IMM, ALU_ADD, 1'b0, 1'b1, M2R_ALU, 1'b0};
                OP_LW:   ctrl_o = '{1'b1, SRC_IMM, ALU_ADD, 1'b1, 1'b0, M2R_MEM, 1'b0};
                OP_JAL:  ctrl_o = '{1'b1, SRC_REG, ALU_ADD, 1'b0, 1'b0, M2R_PC4, 1'b1};
                default: known_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe_seq.sv
// Pipelined control unit: EX/MEM/WB control registers, multi-cycle MUL sequencing, JAL flush.
// Optional load-use interlock is built when LOAD_USE_HAZARD_EN is defined.
module ctrl_pipe_seq
    import ctrl_pkg::*;
#(
    parameter int OP_W       = 8,
    parameter int REG_W      = 5,
    parameter int MUL_CYCLES = 4
) (
    input logic             clk,
    input logic             rst_n,
    ctrl_pipe_seq_if.slave  bus
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             ex_valid_q, ex_valid_d;
    ctrl_t            ex_ctrl_q, ex_ctrl_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic             mem_valid_q, mem_valid_d;
    ctrl_t            mem_ctrl_q, mem_ctrl_d;
    logic [REG_W-1:0] mem_rd_q, mem_rd_d;
    logic             wb_valid_q, wb_valid_d;
    ctrl_t            wb_ctrl_q, wb_ctrl_d;
    logic [REG_W-1:0] wb_rd_q, wb_rd_d;

    ctrl_t id_ctrl;
    logic  id_known;
    logic  ex_is_mul, mul_done, mul_hold, jal_ex, load_use;
    logic  id_ready, pc_src;

    ctrl_decode #(.OP_W(OP_W)) u_decode (
        .op_i    (bus.id_op),
        .valid_i (bus.id_valid),
        .ctrl_o  (id_ctrl),
        .known_o (id_known)
    );

    assign ex_is_mul = ex_valid_q && (ex_ctrl_q.alu_op == ALU_MUL);
    assign jal_ex    = ex_valid_q && ex_ctrl_q.pc_src;

    // A single-cycle MUL is done on entry; otherwise the last BUSY cycle is cnt==1.
    always_comb begin
        if (MUL_CYCLES == 1) mul_done = 1'b1;
        else                 mul_done = (state_q == MUL_BUSY) && (cnt_q == CNT_W'(1));
    end
    assign mul_hold = ex_is_mul && !mul_done;

`ifdef LOAD_USE_HAZARD_EN
    assign load_use = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != '0) && bus.id_valid &&
                      ((uses_rs1(bus.id_op) && (bus.id_rs1 == ex_rd_q)) ||
                       (uses_rs2(bus.id_op) && (bus.id_rs2 == ex_rd_q)));
`else
    assign load_use = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ex_valid_d  = ex_valid_q;
        ex_ctrl_d   = ex_ctrl_q;
        ex_rd_d     = ex_rd_q;
        mem_valid_d = mem_valid_q;
        mem_ctrl_d  = mem_ctrl_q;
        mem_rd_d    = mem_rd_q;
        wb_valid_d  = wb_valid_q;
        wb_ctrl_d   = wb_ctrl_q;
        wb_rd_d     = wb_rd_q;
        id_ready    = 1'b0;
        pc_src      = 1'b0;
        if (!bus.ext_stall) begin
            wb_valid_d = mem_valid_q;
            wb_ctrl_d  = mem_ctrl_q;
            wb_rd_d    = mem_rd_q;
            if (mul_hold) begin
                mem_valid_d = 1'b0;
                mem_ctrl_d  = CTRL_NOP;
                mem_rd_d    = '0;
                if (state_q == MUL_IDLE) begin
                    state_d = MUL_BUSY;
                    cnt_d   = CNT_W'(MUL_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else begin
                mem_valid_d = ex_valid_q;
                mem_ctrl_d  = ex_ctrl_q;
                mem_rd_d    = ex_rd_q;
                state_d     = MUL_IDLE;
                cnt_d       = '0;
                id_ready    = !load_use;
                pc_src      = jal_ex;
                // A JAL in EX consumes the ID slot but squashes it.
                if (load_use || jal_ex || !id_known) begin
                    ex_valid_d = 1'b0;
                    ex_ctrl_d  = CTRL_NOP;
                    ex_rd_d    = '0;
                end else begin
                    ex_valid_d = 1'b1;
                    ex_ctrl_d  = id_ctrl;
                    ex_rd_d    = bus.id_rd;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MUL_IDLE;
            cnt_q       <= '0;
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= CTRL_NOP;
            ex_rd_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_ctrl_q  <= CTRL_NOP;
            mem_rd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_ctrl_q   <= CTRL_NOP;
            wb_rd_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rd_q     <= ex_rd_d;
            mem_valid_q <= mem_valid_d;
            mem_ctrl_q  <= mem_ctrl_d;
            mem_rd_q    <= mem_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_rd_q     <= wb_rd_d;
        end
    end

    assign bus.id_ready      = id_ready;
    assign bus.pc_src        = pc_src;
    assign bus.flush_if      = pc_src;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_alu_src    = ex_valid_q ? ex_ctrl_q.alu_src : 2'b00;
    assign bus.ex_alu_op     = ex_valid_q ? ex_ctrl_q.alu_op : 4'b0000;
    assign bus.ex_mul_done   = ex_is_mul && mul_done;
    assign bus.mem_valid     = mem_valid_q;
    assign bus.mem_read      = mem_valid_q && mem_ctrl_q.mem_read;
    assign bus.mem_write     = mem_valid_q && mem_ctrl_q.mem_write;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_mem_to_reg = wb_valid_q ? wb_ctrl_q.mem_to_reg : 2'b00;
    assign bus.wb_reg_write  = wb_valid_q && wb_ctrl_q.reg_write;
    assign bus.wb_rd         = wb_valid_q ? wb_rd_q : '0;
    assign bus.dbg_mul_state = state_q;

endmodule
